// File: rtl/store_buffer.sv
// store_buffer: in-order store FIFO sharing one data-memory port with loads.
// Loads win the port unless they overlap a buffered store or the buffer is full.
module store_buffer #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       st_valid_i,
  output logic                       st_ready_o,
  input  logic [AWIDTH-1:0]          st_addr_i,
  input  logic [DWIDTH-1:0]          st_data_i,
  input  logic [2:0]                 st_funct3_i,
  input  logic                       ld_valid_i,
  input  logic [AWIDTH-1:0]          ld_addr_i,
  input  logic [2:0]                 ld_funct3_i,
  output logic                       ld_stall_o,
  output logic [AWIDTH-1:0]          mem_addr_o,
  output logic [DWIDTH-1:0]          mem_data_o,
  output logic [2:0]                 mem_funct3_o,
  output logic                       mem_read_en_o,
  output logic                       mem_write_en_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int AW1 = AWIDTH + 1;

  logic [AWIDTH-1:0] addr_q [DEPTH];
  logic [DWIDTH-1:0] data_q [DEPTH];
  logic [2:0]        f3_q   [DEPTH];

  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [CW-1:0] count_q;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic overlap;
  logic ld_grant;
  logic drain;

  logic [PW-1:0]  off;
  logic [AW1-1:0] ld_lo;
  logic [AW1-1:0] ld_hi;
  logic [AW1-1:0] st_lo;
  logic [AW1-1:0] st_hi;

  // byte span of an access; the low two funct3 bits encode size
  function automatic logic [2:0] span_of(input logic [2:0] f);
    logic [2:0] s;
    unique case (f[1:0])
      2'b00:   s = 3'd1;
      2'b01:   s = 3'd2;
      default: s = 3'd4;
    endcase
    return s;
  endfunction

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  assign st_ready_o = !full && !rst;
  assign push       = st_valid_i && st_ready_o;

  assign count_o = count_q;
  assign empty_o = empty;

  // scan live entries for any byte shared with the load (no address wrap)
  always_comb begin
    overlap = 1'b0;
    off     = '0;
    st_lo   = '0;
    st_hi   = '0;
    ld_lo   = {1'b0, ld_addr_i};
    ld_hi   = ld_lo + AW1'(span_of(ld_funct3_i));
    for (int i = 0; i < DEPTH; i++) begin
      off   = PW'(i) - head_q;
      st_lo = {1'b0, addr_q[i]};
      st_hi = st_lo + AW1'(span_of(f3_q[i]));
      if ({1'b0, off} < count_q) begin
        if (ld_lo < st_hi && st_lo < ld_hi)
          overlap = 1'b1;
      end
    end
  end

  assign ld_stall_o = !rst && ld_valid_i && (overlap || full);
  assign ld_grant   = !rst && ld_valid_i && !ld_stall_o;
  assign drain      = !rst && !ld_grant && !empty;
  assign pop        = drain;

  // memory port mux: load, drain head, or idle zeros
  always_comb begin
    mem_addr_o     = '0;
    mem_data_o     = '0;
    mem_funct3_o   = '0;
    mem_read_en_o  = 1'b0;
    mem_write_en_o = 1'b0;
    unique case (1'b1)
      ld_grant: begin
        mem_addr_o    = ld_addr_i;
        mem_funct3_o  = ld_funct3_i;
        mem_read_en_o = 1'b1;
      end
      drain: begin
        mem_addr_o     = addr_q[head_q];
        mem_data_o     = data_q[head_q];
        mem_funct3_o   = f3_q[head_q];
        mem_write_en_o = 1'b1;
      end
      default: ;
    endcase
  end

  // entry storage written at tail on accept
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= st_addr_i;
      data_q[tail_q] <= st_data_i;
      f3_q[tail_q]   <= st_funct3_i;
    end
  end

  // pointers and occupancy; reset drops every buffered store
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push)
        tail_q <= tail_q + 1'b1;
      if (pop)
        head_q <= head_q + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: randomized + directed stimulus against a queue model.
// Model predicts port ownership; monitor scoreboards memory traffic.
module tb_store_buffer;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst;
  logic          st_valid_i;
  logic          st_ready_o;
  logic [AW-1:0] st_addr_i;
  logic [DW-1:0] st_data_i;
  logic [2:0]    st_funct3_i;
  logic          ld_valid_i;
  logic [AW-1:0] ld_addr_i;
  logic [2:0]    ld_funct3_i;
  logic          ld_stall_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_o;
  logic [2:0]    mem_funct3_o;
  logic          mem_read_en_o;
  logic          mem_write_en_o;
  logic [CW-1:0] count_o;
  logic          empty_o;

  store_buffer #(
    .AWIDTH(AW),
    .DWIDTH(DW),
    .DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .st_valid_i    (st_valid_i),
    .st_ready_o    (st_ready_o),
    .st_addr_i     (st_addr_i),
    .st_data_i     (st_data_i),
    .st_funct3_i   (st_funct3_i),
    .ld_valid_i    (ld_valid_i),
    .ld_addr_i     (ld_addr_i),
    .ld_funct3_i   (ld_funct3_i),
    .ld_stall_o    (ld_stall_o),
    .mem_addr_o    (mem_addr_o),
    .mem_data_o    (mem_data_o),
    .mem_funct3_o  (mem_funct3_o),
    .mem_read_en_o (mem_read_en_o),
    .mem_write_en_o(mem_write_en_o),
    .count_o       (count_o),
    .empty_o       (empty_o)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [2:0]    f;
  } st_t;

  typedef struct {
    logic [AW-1:0] a;
    logic [2:0]    f;
  } rd_t;

  st_t mq[$];
  st_t exp_wr[$];
  rd_t exp_rd[$];

  int n_tests;
  int n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  function automatic int span(input logic [2:0] f);
    if (f == 3'b000 || f == 3'b100) return 1;
    if (f == 3'b001 || f == 3'b101) return 2;
    return 4;
  endfunction

  // reference model: evaluates each cycle from the store list
  always @(negedge clk) begin
    int  n;
    bit  ov, full, stall, ldg, drn, rdy;
    longint llo, lhi, slo, shi;
    st_t s;
    rd_t r;
    n = mq.size();
    if (rst) begin
      chk("rst_ready", st_ready_o, 0);
      chk("rst_stall", ld_stall_o, 0);
      chk("rst_we", mem_write_en_o, 0);
      chk("rst_re", mem_read_en_o, 0);
      mq.delete();
      exp_wr.delete();
    end else begin
      full = (n == DEPTH);
      ov = 0;
      llo = longint'(ld_addr_i);
      lhi = llo + span(ld_funct3_i);
      foreach (mq[k]) begin
        slo = longint'(mq[k].a);
        shi = slo + span(mq[k].f);
        if (llo < shi && slo < lhi) ov = 1;
      end
      rdy   = !full;
      stall = ld_valid_i && (ov || full);
      ldg   = ld_valid_i && !stall;
      drn   = !ldg && n > 0;
      chk("count", count_o, n);
      chk("empty", empty_o, n == 0);
      chk("st_ready", st_ready_o, rdy);
      chk("ld_stall", ld_stall_o, stall);
      chk("mem_re", mem_read_en_o, ldg);
      chk("mem_we", mem_write_en_o, drn);
      if (!ldg && !drn)
        chk("idle_bus", {mem_addr_o, mem_data_o, mem_funct3_o}, 0);
      if (ldg) begin
        r.a = ld_addr_i;
        r.f = ld_funct3_i;
        exp_rd.push_back(r);
      end
      if (drn) void'(mq.pop_front());
      if (st_valid_i && rdy) begin
        s.a = st_addr_i;
        s.d = st_data_i;
        s.f = st_funct3_i;
        mq.push_back(s);
        exp_wr.push_back(s);
      end
    end
  end

  // monitor: every memory transaction must match the next expected one
  always @(negedge clk) begin
    st_t e;
    rd_t r;
    #1;
    if (mem_write_en_o === 1'b1) begin
      if (exp_wr.size() == 0) begin
        chk("wr_unexpected", 1, 0);
      end else begin
        e = exp_wr.pop_front();
        chk("wr_txn", {mem_addr_o, mem_data_o, mem_funct3_o},
            {e.a, e.d, e.f});
      end
    end
    if (mem_read_en_o === 1'b1) begin
      if (exp_rd.size() == 0) begin
        chk("rd_unexpected", 1, 0);
      end else begin
        r = exp_rd.pop_front();
        chk("rd_txn", {mem_addr_o, mem_funct3_o}, {r.a, r.f});
      end
    end
  end

  task automatic drive(input bit sv, input logic [AW-1:0] sa,
                       input logic [DW-1:0] sd, input logic [2:0] sf,
                       input bit lv, input logic [AW-1:0] la,
                       input logic [2:0] lf);
    st_valid_i  = sv;
    st_addr_i   = sa;
    st_data_i   = sd;
    st_funct3_i = sf;
    ld_valid_i  = lv;
    ld_addr_i   = la;
    ld_funct3_i = lf;
    @(posedge clk);
    #1;
  endtask

  // hold a store until the buffer takes it, with a load held alongside
  task automatic store_hold(input logic [AW-1:0] sa,
                            input logic [DW-1:0] sd,
                            input bit lv, input logic [AW-1:0] la);
    bit acc;
    int t;
    acc = 0;
    t = 0;
    st_valid_i  = 1;
    st_addr_i   = sa;
    st_data_i   = sd;
    st_funct3_i = 3'b010;
    ld_valid_i  = lv;
    ld_addr_i   = la;
    ld_funct3_i = 3'b010;
    while (!acc && t < 50) begin
      @(negedge clk);
      acc = st_ready_o;
      @(posedge clk);
      #1;
      t++;
    end
    if (!acc) chk("store_timeout", 0, 1);
    st_valid_i = 0;
  endtask

  function automatic logic [AW-1:0] pick();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return '0;
    if (r == 1) return 32'hFFFF_FFFC + AW'($urandom_range(0, 3));
    return 32'h0100_0100 + AW'($urandom_range(0, 31));
  endfunction

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1;
    st_valid_i = 0; st_addr_i = 0; st_data_i = 0; st_funct3_i = 0;
    ld_valid_i = 0; ld_addr_i = 0; ld_funct3_i = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    drive(0, 0, 0, 0, 0, 0, 0);

    // single word store drains the next cycle
    drive(1, 32'h0100_0010, 32'hDEAD_BEEF, 3'b010, 0, 0, 0);
    repeat (3) drive(0, 0, 0, 0, 0, 0, 0);

    // fill while a non-overlapping load hogs the port
    for (int k = 0; k < 5; k++)
      store_hold(32'h0100_0000 + AW'(4 * k), DW'(k + 32'hA0),
                 1, 32'h0100_0100);
    repeat (8) drive(0, 0, 0, 0, 0, 0, 0);

    // byte store blocks an overlapping word load
    drive(1, 32'h0100_0013, 32'h55, 3'b000, 0, 0, 0);
    repeat (3) drive(0, 0, 0, 0, 1, 32'h0100_0010, 3'b010);
    // half store adjacent to a byte load: no overlap
    drive(1, 32'h0100_0014, 32'h1234, 3'b001, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 32'h0100_0013, 3'b000);
    repeat (2) drive(0, 0, 0, 0, 0, 0, 0);

    // continuous enqueue with drain every cycle
    for (int k = 0; k < 3 * DEPTH; k++)
      drive(1, 32'h0100_0200 + AW'(4 * k), $urandom, 3'b010, 0, 0, 0);
    repeat (3) drive(0, 0, 0, 0, 0, 0, 0);

    // reset while draining a partly full buffer
    for (int k = 0; k < DEPTH; k++)
      drive(1, 32'h0100_0300 + AW'(4 * k), $urandom, 3'b010,
            1, 32'h0100_0400, 3'b010);
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1;
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 0;
    repeat (4) drive(0, 0, 0, 0, 0, 0, 0);

    // top-of-address store must not alias a load at zero
    drive(1, 32'hFFFF_FFFE, 32'h77, 3'b010, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 32'h0, 3'b010);

    // randomized traffic with occasional reset
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 1), pick(), $urandom,
            3'($urandom_range(0, 7)),
            $urandom_range(0, 2) == 0, pick(),
            3'($urandom_range(0, 7)));
    end
    rst = 0;
    repeat (3 * DEPTH + 5) drive(0, 0, 0, 0, 0, 0, 0);
    chk("wr_left", exp_wr.size(), 0);
    chk("rd_left", exp_rd.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
